// File: rtl/jk_bank_pkg.sv
// Shared encodings for the JK bank arbiter: requester op codes and FSM states.
package jk_bank_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_APPLY = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Two-requester handshake bus for jk_bank_arbiter; master = requester side, slave = arbiter.
interface jk_bank_arbiter_if #(
  parameter int unsigned N_BITS = 4,
  parameter int unsigned SEL_W  = 2
);
  logic              req0;
  logic [1:0]        op0;
  logic [SEL_W-1:0]  sel0;
  logic              req1;
  logic [1:0]        op1;
  logic [SEL_W-1:0]  sel1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic              busy;
  logic [N_BITS-1:0] q;

  modport master (
    output req0, op0, sel0, req1, op1, sel1,
    input  gnt0, gnt1, done0, done1, busy, q
  );

  modport slave (
    input  req0, op0, sel0, req1, op1, sel1,
    output gnt0, gnt1, done0, done1, busy, q
  );
endinterface

// File: rtl/jk_ff_en.sv
// Enable-gated JK flip-flop with asynchronous active-low clear.
module jk_ff_en (
  input  logic clk,
  input  logic reset,
  input  logic E,
  input  logic J,
  input  logic K,
  output logic Q
);
  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (E) begin
      unique case ({J, K})
        2'b00: q_d = q_q;
        2'b01: q_d = 1'b0;
        2'b10: q_d = 1'b1;
        2'b11: q_d = ~q_q;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign Q = q_q;
endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sequencing single-bit JK ops from two requesters into a JK bank.
// Define JKARB_FIXED_PRIO_EN to make requester 0 always win ties (no rotating pointer).
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int unsigned N_BITS = 4,
  parameter int unsigned SEL_W  = 2
) (
  input logic              clk,
  input logic              reset,
  jk_bank_arbiter_if.slave bus
);
  state_e             state_q, state_d;
  logic               winner_q, winner_d;
  logic [1:0]         op_q, op_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               done0_q, done0_d, done1_q, done1_d;
  logic               busy_q, busy_d;
  logic               pick;
  logic [N_BITS-1:0]  q_bank;

`ifdef JKARB_FIXED_PRIO_EN
  assign pick = ~bus.req0;
`else
  logic ptr_q, ptr_d;
  assign pick = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
`endif

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    op_d     = op_q;
    sel_d    = sel_q;
`ifndef JKARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d  = S_GRANT;
          winner_d = pick;
          op_d     = pick ? bus.op1 : bus.op0;
          sel_d    = pick ? bus.sel1 : bus.sel0;
        end
      end
      S_GRANT: state_d = S_APPLY;
      S_APPLY: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
`ifndef JKARB_FIXED_PRIO_EN
        ptr_d   = ~winner_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state itself.
    gnt0_d  = (state_d == S_GRANT) && !winner_d;
    gnt1_d  = (state_d == S_GRANT) &&  winner_d;
    done0_d = (state_d == S_DONE)  && !winner_d;
    done1_d = (state_d == S_DONE)  &&  winner_d;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      winner_q <= 1'b0;
      op_q     <= OP_HOLD;
      sel_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      op_q     <= op_d;
      sel_q    <= sel_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

`ifndef JKARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Out-of-range selects match no index, so the bank sees no enable at all.
  for (genvar i = 0; i < N_BITS; i++) begin : g_bank
    logic en;
    assign en = (state_q == S_APPLY) && (32'(sel_q) == i);
    jk_ff_en u_ff (
      .clk   (clk),
      .reset (reset),
      .E     (en),
      .J     (en & op_q[1]),
      .K     (en & op_q[0]),
      .Q     (q_bank[i])
    );
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.busy  = busy_q;
  assign bus.q     = q_bank;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_jk_bank_arbiter;
  import jk_bank_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter_if #(.N_BITS(4), .SEL_W(2)) bus ();
  jk_bank_arbiter_if #(.N_BITS(3), .SEL_W(2)) bus3 ();

  jk_bank_arbiter #(.N_BITS(4), .SEL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  jk_bank_arbiter #(.N_BITS(3), .SEL_W(2)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // One transaction from a single requester with exact latency checks.
  task automatic do_txn(input bit who, input logic [1:0] op, input logic [1:0] sel,
                        input logic [3:0] exp_q, input string tag);
    if (who) begin bus.req1 = 1'b1; bus.op1 = op; bus.sel1 = sel; end
    else     begin bus.req0 = 1'b1; bus.op0 = op; bus.sel0 = sel; end
    tick();
    tests++;
    if ({bus.gnt1, bus.gnt0, bus.busy} !== {who, !who, 1'b1}) begin
      fails++;
      $display("FAIL %s_gnt: got gnt1/gnt0/busy=%b want %b", tag,
               {bus.gnt1, bus.gnt0, bus.busy}, {who, !who, 1'b1});
    end
    tick();
    tests++;
    if ({bus.gnt1, bus.gnt0, bus.done1, bus.done0} !== 4'b0000) begin
      fails++;
      $display("FAIL %s_apply: got gnt/done=%b want 0000", tag,
               {bus.gnt1, bus.gnt0, bus.done1, bus.done0});
    end
    tick();
    tests++;
    if ({bus.done1, bus.done0, bus.q} !== {who, !who, exp_q}) begin
      fails++;
      $display("FAIL %s_done: got done1/done0/q=%b want %b", tag,
               {bus.done1, bus.done0, bus.q}, {who, !who, exp_q});
    end
    if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    tick();
    tests++;
    if ({bus.busy, bus.done1, bus.done0} !== 3'b000) begin
      fails++;
      $display("FAIL %s_idle: got busy/done=%b want 000", tag, {bus.busy, bus.done1, bus.done0});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tests++;
    if ({bus.q, bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 9'b0) begin
      fails++;
      $display("FAIL reset_hold: got q/busy/gnt/done=%b want 0",
               {bus.q, bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1});
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({bus.q, bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 9'b0) begin
        fails++;
        $display("FAIL reset_idle%0d: got q/busy/gnt/done=%b want 0", i,
                 {bus.q, bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1});
      end
    end
  endtask

  task automatic test_single_op();
    do_txn(1'b0, OP_SET, 2'd2, 4'b0100, "single_set");
  endtask

  task automatic test_toggle_sequence();
    logic [1:0] ops [4] = '{OP_TGL, OP_TGL, OP_CLR, OP_HOLD};
    logic [3:0] exps[4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) do_txn(1'b0, ops[i], 2'd2, exps[i], $sformatf("seq%0d", i));
  endtask

  task automatic test_contention();
    int gap;
    pulse_reset();
    bus.req0 = 1'b1; bus.op0 = OP_SET; bus.sel0 = 2'd0;
    bus.req1 = 1'b1; bus.op1 = OP_SET; bus.sel1 = 2'd3;
`ifdef JKARB_FIXED_PRIO_EN
    for (int i = 0; i < 24; i++) begin
      tick();
      tests++;
      if (bus.gnt1 !== 1'b0) begin
        fails++;
        $display("FAIL prio_no_gnt1: cycle %0d got gnt1=%b want 0", i, bus.gnt1);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if ({bus.q, bus.busy} !== {4'b0001, 1'b0}) begin
      fails++;
      $display("FAIL prio_final: got q/busy=%b want 00010", {bus.q, bus.busy});
    end
`else
    tick();
    tests++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
      fails++;
      $display("FAIL rr_first: got gnt1/gnt0=%b want 01", {bus.gnt1, bus.gnt0});
    end
    tick();
    tick();
    tests++;
    if ({bus.done0, bus.q} !== {1'b1, 4'b0001}) begin
      fails++;
      $display("FAIL rr_done0: got done0/q=%b want 10001", {bus.done0, bus.q});
    end
    bus.req0 = 1'b0;
    gap = 2;
    while (bus.gnt1 !== 1'b1 && gap < 10) begin
      tick();
      gap++;
    end
    tests++;
    if (gap !== 4) begin
      fails++;
      $display("FAIL rr_gap: got gnt1 %0d cycles after gnt0 want 4", gap);
    end
    tick();
    tick();
    tests++;
    if ({bus.done1, bus.q} !== {1'b1, 4'b1001}) begin
      fails++;
      $display("FAIL rr_final: got done1/q=%b want 11001", {bus.done1, bus.q});
    end
    bus.req1 = 1'b0;
    tick();
`endif
  endtask

  task automatic test_abort();
    bus.req1 = 1'b1; bus.op1 = OP_SET; bus.sel1 = 2'd1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if ({bus.q, bus.busy} !== 5'b0) begin
      fails++;
      $display("FAIL abort_clear: got q/busy=%b want 00000", {bus.q, bus.busy});
    end
    tick();
    tests++;
    if ({bus.done1, bus.done0, bus.gnt1, bus.gnt0, bus.q} !== 8'b0) begin
      fails++;
      $display("FAIL abort_nodone: got done/gnt/q=%b want 0",
               {bus.done1, bus.done0, bus.gnt1, bus.gnt0, bus.q});
    end
    bus.req1 = 1'b0;
    reset = 1'b1;
    tick();
    do_txn(1'b0, OP_SET, 2'd1, 4'b0010, "after_abort");
  endtask

  task automatic test_out_of_range();
    bus3.req0 = 1'b1; bus3.op0 = OP_SET; bus3.sel0 = 2'd3;
    tick();
    tests++;
    if (bus3.gnt0 !== 1'b1) begin
      fails++;
      $display("FAIL oor_gnt: got gnt0=%b want 1", bus3.gnt0);
    end
    tick();
    tick();
    tests++;
    if ({bus3.done0, bus3.q} !== 4'b1000) begin
      fails++;
      $display("FAIL oor_done: got done0/q=%b want 1000", {bus3.done0, bus3.q});
    end
    bus3.req0 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit         pend[2];
    logic [1:0] ops[2];
    logic [1:0] sels[2];
    logic [3:0] q_m;
    bit         fav;
    bit         w;
    pulse_reset();
    q_m = 4'b0;
    fav = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int n = 0; n < 60; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(1, 0) == 1)) begin
          pend[r] = 1'b1;
          ops[r]  = 2'($urandom_range(3, 0));
          sels[r] = 2'($urandom_range(3, 0));
        end
      end
      if (!pend[0] && !pend[1]) begin
        w = 1'($urandom_range(1, 0));
        pend[w] = 1'b1;
        ops[w]  = 2'($urandom_range(3, 0));
        sels[w] = 2'($urandom_range(3, 0));
      end
      bus.req0 = pend[0]; bus.op0 = ops[0]; bus.sel0 = sels[0];
      bus.req1 = pend[1]; bus.op1 = ops[1]; bus.sel1 = sels[1];
      w = (pend[0] && pend[1]) ? fav : pend[1];
      case (ops[w])
        OP_CLR:  q_m[sels[w]] = 1'b0;
        OP_SET:  q_m[sels[w]] = 1'b1;
        OP_TGL:  q_m[sels[w]] = ~q_m[sels[w]];
        default: ;
      endcase
      tick();
      tests++;
      if ({bus.gnt1, bus.gnt0} !== {w, !w}) begin
        fails++;
        $display("FAIL rand%0d_gnt: got gnt1/gnt0=%b want %b", n, {bus.gnt1, bus.gnt0}, {w, !w});
      end
      tick();
      tick();
      tests++;
      if ({bus.done1, bus.done0, bus.q} !== {w, !w, q_m}) begin
        fails++;
        $display("FAIL rand%0d_done: got done1/done0/q=%b want %b", n,
                 {bus.done1, bus.done0, bus.q}, {w, !w, q_m});
      end
      pend[w] = 1'b0;
      if (w) bus.req1 = 1'b0; else bus.req0 = 1'b0;
`ifdef JKARB_FIXED_PRIO_EN
      fav = 1'b0;
`else
      fav = ~w;
`endif
      tick();
      tests++;
      if (bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL rand%0d_idle: got busy=%b want 0", n, bus.busy);
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.op0 = OP_HOLD; bus.sel0 = '0;
    bus.req1 = 1'b0; bus.op1 = OP_HOLD; bus.sel1 = '0;
    bus3.req0 = 1'b0; bus3.op0 = OP_HOLD; bus3.sel0 = '0;
    bus3.req1 = 1'b0; bus3.op1 = OP_HOLD; bus3.sel1 = '0;
    @(negedge clk);
    test_reset();
    test_single_op();
    test_toggle_sequence();
    test_contention();
    test_abort();
    test_out_of_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
